// File: rtl/nr_iter_sequencer.sv
// nr_iter_sequencer
// Sequencing controller for the Broyden-updated Newton-Raphson datapath.
// It launches one first_iteration pass, then gen_iteration passes until
// n = max(num_cycles,1) iterations are complete. It owns the iterate
// registers (x, invJ) that feed back into gen_iteration. A watchdog
// aborts to ERR if a datapath strobe does not arrive in time.
//
// Build option: define NR_CONVERGE_EN to stop early when a gen pass
// returns an x identical to the current iterate (sets converged).
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start, num_cycles     solve request, iteration count (0 treated as 1)
//   in_x                  seed vector {x2,x1,x0}, latched on accepted start
//   first_go/first_stb    launch pulse / result strobe of first_iteration
//   first_x, first_invj   first_iteration results
//   gen_go/gen_stb        launch pulse / result strobe of gen_iteration
//   gen_x, gen_invj       gen_iteration results
//   seed_x                latched seed for first_iteration
//   x_out, invj_out       current iterate and inverse Jacobian
//   iter_count            completed iterations
//   busy, done, err       solve status
//   converged             early-exit flag (0 unless NR_CONVERGE_EN)
module nr_iter_sequencer #(
    parameter int W           = 32,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [5:0]        num_cycles,
    input  logic [3*W-1:0]    in_x,
    output logic              first_go,
    input  logic              first_stb,
    input  logic [3*W-1:0]    first_x,
    input  logic [12*W-1:0]   first_invj,
    output logic              gen_go,
    input  logic              gen_stb,
    input  logic [3*W-1:0]    gen_x,
    input  logic [12*W-1:0]   gen_invj,
    output logic [3*W-1:0]    seed_x,
    output logic [3*W-1:0]    x_out,
    output logic [12*W-1:0]   invj_out,
    output logic [5:0]        iter_count,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              converged
);

    typedef enum logic [2:0] {
        S_IDLE, S_F_LAUNCH, S_F_WAIT, S_G_LAUNCH, S_G_WAIT, S_DONE, S_ERR
    } state_t;

    localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
    // Expiry is detected one count early so that exactly TIMEOUT_CYC
    // strobe-less wait cycles lead to ERR.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    state_t          state_q, state_d;
    logic [5:0]      n_q;
    logic [WD_W-1:0] wd_q;
    logic            accept_start;
    logic            in_wait;
    logic            wd_expired;
    logic            conv_hit;
    logic [5:0]      iter_inc;

    assign accept_start = start && (state_q inside {S_IDLE, S_DONE, S_ERR});
    assign in_wait      = (state_q == S_F_WAIT) || (state_q == S_G_WAIT);
    assign wd_expired   = (wd_q == WD_LAST);
    assign iter_inc     = iter_count + 6'd1;

`ifdef NR_CONVERGE_EN
    assign conv_hit = (gen_x == x_out);
`else
    assign conv_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; a strobe beats a simultaneous watchdog expiry.
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (latch).
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR:
                if (start) state_d = S_F_LAUNCH;
            S_F_LAUNCH:
                state_d = S_F_WAIT;
            S_F_WAIT:
                if (first_stb)       state_d = (n_q == 6'd1) ? S_DONE : S_G_LAUNCH;
                else if (wd_expired) state_d = S_ERR;
            S_G_LAUNCH:
                state_d = S_G_WAIT;
            S_G_WAIT:
                if (gen_stb)         state_d = (iter_inc == n_q || conv_hit) ? S_DONE : S_G_LAUNCH;
                else if (wd_expired) state_d = S_ERR;
            default:
                state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state. Go pulses are masked by rst so a reset
    // landing on a launch cycle never reaches the datapath.
    always_comb begin
        first_go = 1'b0;
        gen_go   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        unique case (state_q)
            S_F_LAUNCH: begin first_go = !rst; busy = 1'b1; end
            S_G_LAUNCH: begin gen_go   = !rst; busy = 1'b1; end
            S_F_WAIT,
            S_G_WAIT:   busy = 1'b1;
            S_DONE:     done = 1'b1;
            S_ERR:      begin done = 1'b1; err = 1'b1; end
            default:    ;
        endcase
    end

    // Iterate registers, pass counter and watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            seed_x     <= '0;
            x_out      <= '0;
            invj_out   <= '0;
            iter_count <= '0;
            n_q        <= '0;
            wd_q       <= '0;
        end else begin
            if (accept_start) begin
                seed_x     <= in_x;
                n_q        <= (num_cycles == 6'd0) ? 6'd1 : num_cycles;
                iter_count <= '0;
            end
            if (state_q == S_F_WAIT && first_stb) begin
                x_out      <= first_x;
                invj_out   <= first_invj;
                iter_count <= 6'd1;
            end
            if (state_q == S_G_WAIT && gen_stb) begin
                x_out      <= gen_x;
                invj_out   <= gen_invj;
                iter_count <= iter_inc;
            end
            if (in_wait && state_d == state_q) wd_q <= wd_q + 1'b1;
            else                               wd_q <= '0;
        end
    end

`ifdef NR_CONVERGE_EN
    always_ff @(posedge clk) begin
        if (rst || accept_start)                     converged <= 1'b0;
        else if (state_q == S_G_WAIT && gen_stb && conv_hit) converged <= 1'b1;
    end
`else
    assign converged = 1'b0;
`endif

endmodule

// File: tb/tb_nr_iter_sequencer.sv
module tb_nr_iter_sequencer;

    localparam int W  = 32;
    localparam int TO = 1023;

    logic          clk = 1'b0;
    logic          rst, start, first_stb, gen_stb;
    logic [5:0]    num_cycles;
    logic [95:0]   in_x, first_x, gen_x;
    logic [383:0]  first_invj, gen_invj;
    logic          first_go, gen_go, busy, done, err, converged;
    logic [95:0]   seed_x, x_out;
    logic [383:0]  invj_out;
    logic [5:0]    iter_count;

    nr_iter_sequencer #(.W(W), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .num_cycles(num_cycles), .in_x(in_x),
        .first_go(first_go), .first_stb(first_stb), .first_x(first_x), .first_invj(first_invj),
        .gen_go(gen_go), .gen_stb(gen_stb), .gen_x(gen_x), .gen_invj(gen_invj),
        .seed_x(seed_x), .x_out(x_out), .invj_out(invj_out), .iter_count(iter_count),
        .busy(busy), .done(done), .err(err), .converged(converged)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_first = 0;
    int n_gen   = 0;

    always @(negedge clk) begin
        if (first_go) n_first <= n_first + 1;
        if (gen_go)   n_gen   <= n_gen + 1;
    end

    typedef struct {
        logic [95:0]  x;
        logic [383:0] j;
        logic [5:0]   it;
    } exp_t;

    exp_t         sb[$];
    logic [95:0]  cur_x = '0;
    logic [383:0] cur_j = '0;
    int           exp_iter = 0;

    task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [95:0] rand_x();
        logic [95:0] r;
        for (int i = 0; i < 3; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [383:0] rand_j();
        logic [383:0] r;
        for (int i = 0; i < 12; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic wait_go(input bit gen);
        int k = 0;
        while (!(gen ? gen_go : first_go) && k < 50) begin
            tick();
            k++;
        end
        check(gen ? "gen_go_seen" : "first_go_seen", 384'(gen ? gen_go : first_go), 384'(1));
    endtask

    // Drive one result strobe after dly cycles; the expected register
    // contents are queued when driven and compared once the DUT updates.
    task automatic deliver(input bit gen, input int dly, input logic [95:0] xv, input logic [383:0] jv);
        exp_t e;
        repeat (dly) tick();
        if (gen) begin gen_stb = 1'b1; gen_x = xv; gen_invj = jv; end
        else     begin first_stb = 1'b1; first_x = xv; first_invj = jv; end
        exp_iter++;
        e.x = xv; e.j = jv; e.it = 6'(exp_iter);
        sb.push_back(e);
        cur_x = xv;
        cur_j = jv;
        tick();
        first_stb = 1'b0;
        gen_stb   = 1'b0;
        e = sb.pop_front();
        check("x_out", 384'(x_out), 384'(e.x));
        check("invj_out", invj_out, e.j);
        check("iter_count", 384'(iter_count), 384'(e.it));
    endtask

    task automatic do_pass(input bit gen, input int dly, input logic [95:0] xv, input logic [383:0] jv);
        wait_go(gen);
        deliver(gen, dly, xv, jv);
    endtask

    task automatic do_start(input logic [5:0] nc, input logic [95:0] seed);
        start = 1'b1; num_cycles = nc; in_x = seed;
        tick();
        start = 1'b0;
        exp_iter = 0;
        check("seed_x", 384'(seed_x), 384'(seed));
        check("busy_after_start", 384'(busy), 384'(1));
        check("done_cleared", 384'(done), 384'(0));
        check("err_cleared", 384'(err), 384'(0));
        check("iter_cleared", 384'(iter_count), 384'(0));
    endtask

    task automatic run_solve(input logic [5:0] nc, input int dly);
        int f0 = n_first;
        int g0 = n_gen;
        int nn = (nc == 6'd0) ? 1 : int'(nc);
        do_start(nc, rand_x());
        for (int p = 0; p < nn; p++) do_pass(p > 0, dly, rand_x(), rand_j());
        check("done_end", 384'(done), 384'(1));
        check("busy_end", 384'(busy), 384'(0));
        check("err_end", 384'(err), 384'(0));
        check("first_go_count", 384'(n_first - f0), 384'(1));
        check("gen_go_count", 384'(n_gen - g0), 384'(nn - 1));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_x"}, 384'(x_out), 384'(0));
        check({tag, "_invj"}, invj_out, 384'(0));
        check({tag, "_seed"}, 384'(seed_x), 384'(0));
        check({tag, "_iter"}, 384'(iter_count), 384'(0));
        check({tag, "_status"}, 384'({first_go, gen_go, busy, done, err, converged}), 384'(0));
    endtask

    initial begin
        int k;
        rst = 1'b1; start = 1'b0; num_cycles = '0; in_x = '0;
        first_stb = 1'b0; gen_stb = 1'b0;
        first_x = '0; gen_x = '0; first_invj = '0; gen_invj = '0;
        tick();
        tick();
        rst = 1'b0;
        check_all_zero("reset");

        // Strobes while idle must be ignored
        first_stb = 1'b1; gen_stb = 1'b1;
        first_x = rand_x(); gen_x = rand_x(); first_invj = rand_j(); gen_invj = rand_j();
        tick();
        first_stb = 1'b0; gen_stb = 1'b0;
        tick();
        check_all_zero("idle_stb");

        // Nominal solves, including the num_cycles 0/1 corner
        run_solve(6'd4, 5);
        check("converged_nominal", 384'(converged), 384'(0));
        run_solve(6'd0, 1);
        run_solve(6'd1, 3);

        // Stray strobes mid-solve
        do_start(6'd3, rand_x());
        first_stb = 1'b1; first_x = rand_x(); first_invj = rand_j();
        tick();                                   // strobe during F_LAUNCH: stale
        first_stb = 1'b0;
        check("stale_launch_iter", 384'(iter_count), 384'(0));
        check("stale_launch_x", 384'(x_out), 384'(cur_x));
        gen_stb = 1'b1; gen_x = rand_x(); gen_invj = rand_j();
        tick();                                   // gen_stb during F_WAIT
        gen_stb = 1'b0;
        check("gen_in_fwait_iter", 384'(iter_count), 384'(0));
        check("gen_in_fwait_x", 384'(x_out), 384'(cur_x));
        check("gen_in_fwait_busy", 384'(busy), 384'(1));
        deliver(1'b0, 1, rand_x(), rand_j());
        wait_go(1'b1);
        first_stb = 1'b1; gen_stb = 1'b1; first_x = rand_x(); gen_x = rand_x();
        tick();                                   // strobes during G_LAUNCH
        first_stb = 1'b0; gen_stb = 1'b0;
        check("stb_in_glaunch_iter", 384'(iter_count), 384'(1));
        check("stb_in_glaunch_x", 384'(x_out), 384'(cur_x));
        check("stb_in_glaunch_invj", invj_out, cur_j);
        deliver(1'b1, 2, rand_x(), rand_j());
        do_pass(1'b1, 2, rand_x(), rand_j());
        check("stray_done", 384'(done), 384'(1));

        // Watchdog: withhold gen_stb on pass 2
        do_start(6'd4, rand_x());
        do_pass(1'b0, 2, rand_x(), rand_j());
        wait_go(1'b1);
        k = 0;
        while (!err && k < TO + 20) begin
            tick();
            k++;
        end
        check("wd_cycles", 384'(k), 384'(TO + 1));
        check("wd_err", 384'(err), 384'(1));
        check("wd_done", 384'(done), 384'(1));
        check("wd_busy", 384'(busy), 384'(0));
        check("wd_x_hold", 384'(x_out), 384'(cur_x));
        check("wd_invj_hold", invj_out, cur_j);
        check("wd_iter_hold", 384'(iter_count), 384'(1));
        do_start(6'd1, rand_x());                 // checks err cleared
        do_pass(1'b0, 1, rand_x(), rand_j());
        check("after_wd_done", 384'(done), 384'(1));

        // Reset while waiting on pass 3
        do_start(6'd5, rand_x());
        do_pass(1'b0, 1, rand_x(), rand_j());
        do_pass(1'b1, 1, rand_x(), rand_j());
        wait_go(1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("rst_gwait");
        cur_x = '0; cur_j = '0;

        // Reset coinciding with the launch cycle: no go pulse leaks out
        do_start(6'd2, rand_x());
        rst = 1'b1;
        #1;
        check("rst_launch_go", 384'(first_go), 384'(0));
        tick();
        rst = 1'b0;
        check_all_zero("rst_launch");
        run_solve(6'd2, 1);

        // Convergence: pass 3 returns the current iterate unchanged
        do_start(6'd10, rand_x());
        do_pass(1'b0, 2, rand_x(), rand_j());
        do_pass(1'b1, 2, rand_x(), rand_j());
        wait_go(1'b1);
        deliver(1'b1, 3, cur_x, rand_j());
`ifdef NR_CONVERGE_EN
        check("conv_flag", 384'(converged), 384'(1));
        check("conv_done", 384'(done), 384'(1));
        check("conv_busy", 384'(busy), 384'(0));
`else
        check("noconv_flag", 384'(converged), 384'(0));
        check("noconv_busy", 384'(busy), 384'(1));
        for (int p = 3; p < 10; p++) do_pass(1'b1, 1, rand_x(), rand_j());
        check("noconv_done", 384'(done), 384'(1));
        check("noconv_flag_end", 384'(converged), 384'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
